// File: rtl/hp_bar_pkg.sv
// Shared types and helpers for the animated HP bar overlay.
package hp_bar_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HEAL  = 2'd3
    } bar_state_t;

    // Bits needed to hold 0..hp_max.
    function automatic int hp_width(input int hp_max);
        return $clog2(hp_max + 1);
    endfunction

    // Limit a requested HP value to the bar's maximum.
    function automatic int clamp_hp(input int v, input int hp_max);
        return (v > hp_max) ? hp_max : v;
    endfunction

endpackage

// File: rtl/hp_bar_chan.sv
// Per-bar animation channel: front segment, damage trail, hold/heal timers.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | front == target; trail tracks front
// ST_HOLD  | damage taken, trail frozen for HOLD_FRAMES frames
// ST_DRAIN | trail drops one HP per frame until it meets front
// ST_HEAL  | front (and trail) climb one HP every HEAL_DIV frames
module hp_bar_chan
    import hp_bar_pkg::*;
#(
    parameter int HP_MAX      = 20,
    parameter int HPW         = 5,
    parameter int HOLD_FRAMES = 30,
    parameter int HEAL_DIV    = 4
) (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic           i_tick,
    input  logic [HPW-1:0] i_tgt,
    output logic [HPW-1:0] o_front,
    output logic [HPW-1:0] o_trail,
    output logic           o_busy
);

    localparam int HCW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam int HDW = (HEAL_DIV > 1) ? $clog2(HEAL_DIV) : 1;

    bar_state_t     r_state, w_state_nxt;
    logic [HPW-1:0] r_front, w_front_nxt;
    logic [HPW-1:0] r_trail, w_trail_nxt;
    logic [HCW-1:0] r_hold, w_hold_nxt;
    logic [HDW-1:0] r_heal, w_heal_nxt;

    // State and datapath registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_front <= HPW'(HP_MAX);
            r_trail <= HPW'(HP_MAX);
            r_hold  <= '0;
            r_heal  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_front <= w_front_nxt;
            r_trail <= w_trail_nxt;
            r_hold  <= w_hold_nxt;
            r_heal  <= w_heal_nxt;
        end
    end

    // Next-state rules, applied only on a frame tick; damage always wins.
    always_comb begin
        w_state_nxt = r_state;
        w_front_nxt = r_front;
        w_trail_nxt = r_trail;
        w_hold_nxt  = r_hold;
        w_heal_nxt  = r_heal;
        if (i_tick) begin
            if (i_tgt < r_front) begin
                w_front_nxt = i_tgt;
                w_trail_nxt = (r_trail < r_front) ? r_front : r_trail;
                w_hold_nxt  = HCW'(HOLD_FRAMES - 1);
                w_state_nxt = ST_HOLD;
            end else begin
                unique case (r_state)
                    ST_HOLD: begin
                        if (r_hold == '0) w_state_nxt = ST_DRAIN;
                        else              w_hold_nxt  = r_hold - HCW'(1);
                    end
                    ST_DRAIN: begin
                        if (r_trail > r_front) begin
                            w_trail_nxt = r_trail - HPW'(1);
                            if ((r_trail - HPW'(1)) == r_front) w_state_nxt = ST_IDLE;
                        end else begin
                            w_trail_nxt = r_front;
                            w_state_nxt = ST_IDLE;
                        end
                    end
                    ST_HEAL: begin
                        // Target pulled back to exactly front mid-heal: stop climbing.
                        if (i_tgt == r_front) begin
                            w_state_nxt = ST_IDLE;
                        end else if (r_heal == HDW'(HEAL_DIV - 1)) begin
                            w_heal_nxt  = '0;
                            w_front_nxt = r_front + HPW'(1);
                            w_trail_nxt = r_trail + HPW'(1);
                            if ((r_front + HPW'(1)) == i_tgt) w_state_nxt = ST_IDLE;
                        end else begin
                            w_heal_nxt = r_heal + HDW'(1);
                        end
                    end
                    default: begin
                        if (i_tgt > r_front) begin
                            w_state_nxt = ST_HEAL;
                            w_heal_nxt  = '0;
                        end else begin
                            w_trail_nxt = r_front;
                        end
                    end
                endcase
            end
        end
    end

    assign o_front = r_front;
    assign o_trail = r_trail;
    assign o_busy  = (r_state != ST_IDLE);

endmodule

// File: rtl/hp_bar_anim.sv
// Animated N-bar HP overlay: frame tick detect, per-bar channels, pixel
// classification and one-cycle output registers.
// Optional build macro LOW_HP_BLINK_EN: blinks the front segment of any bar
// at low (non-zero) HP using a 4-bit frame counter.
module hp_bar_anim
    import hp_bar_pkg::*;
#(
    parameter int NUM_BARS    = 2,
    parameter int HP_MAX      = 20,
    parameter int PX_PER_HP   = 10,
    parameter int BAR_LX      = 86,
    parameter int BAR_RX      = 555,
    parameter int BAR_Y0      = 38,
    parameter int BAR_H       = 20,
    parameter int ROW_PITCH   = 30,
    parameter int HOLD_FRAMES = 30,
    parameter int HEAL_DIV    = 4,
    localparam int HPW        = hp_width(HP_MAX)
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    frame_clk,
    input  logic                    exist_hp,
    input  logic [9:0]              DrawX,
    input  logic [9:0]              DrawY,
    input  logic [NUM_BARS*HPW-1:0] hp_in,
    output logic [NUM_BARS-1:0]     is_bar,
    output logic [NUM_BARS-1:0]     is_trail,
    output logic [9:0]              bar_col,
    output logic                    anim_busy
);

    logic                r_frame_clk_q;
    logic                w_tick;
    logic [10:0]         w_x, w_y;
    logic [HPW-1:0]      w_tgt   [NUM_BARS];
    logic [HPW-1:0]      w_front [NUM_BARS];
    logic [HPW-1:0]      w_trail [NUM_BARS];
    logic [10:0]         w_col   [NUM_BARS];
    logic [NUM_BARS-1:0] w_busy;
    logic [NUM_BARS-1:0] w_bar_hit;
    logic [NUM_BARS-1:0] w_trail_hit;
    logic [NUM_BARS-1:0] w_blink_ok;
    logic [9:0]          w_col_sel;

    logic [NUM_BARS-1:0] r_is_bar;
    logic [NUM_BARS-1:0] r_is_trail;
    logic [9:0]          r_bar_col;

    assign w_x = {1'b0, DrawX};
    assign w_y = {1'b0, DrawY};

    // Rising edge of the vsync-rate level gives one tick per frame.
    always_ff @(posedge Clk) begin
        if (Reset) r_frame_clk_q <= 1'b0;
        else       r_frame_clk_q <= frame_clk;
    end
    assign w_tick = frame_clk & ~r_frame_clk_q;

`ifdef LOW_HP_BLINK_EN
    logic [3:0] r_blink_cnt;

    // Free-running frame counter; bit 3 gives the 8-on/8-off blink phase.
    always_ff @(posedge Clk) begin
        if (Reset)       r_blink_cnt <= '0;
        else if (w_tick) r_blink_cnt <= r_blink_cnt + 4'd1;
    end
`endif

    for (genvar g = 0; g < NUM_BARS; g++) begin : g_bar
        localparam int ROW_Y = BAR_Y0 + (g / 2) * ROW_PITCH;

        logic        w_in_row;
        logic        w_valid;
        logic [10:0] w_front_px;
        logic [10:0] w_trail_px;

        assign w_tgt[g] = HPW'(clamp_hp(32'(hp_in[g*HPW +: HPW]), HP_MAX));

        hp_bar_chan #(
            .HP_MAX      (HP_MAX),
            .HPW         (HPW),
            .HOLD_FRAMES (HOLD_FRAMES),
            .HEAL_DIV    (HEAL_DIV)
        ) u_chan (
            .i_clk   (Clk),
            .i_reset (Reset),
            .i_tick  (w_tick),
            .i_tgt   (w_tgt[g]),
            .o_front (w_front[g]),
            .o_trail (w_trail[g]),
            .o_busy  (w_busy[g])
        );

        assign w_in_row = (w_y >= 11'(ROW_Y)) && (w_y < 11'(ROW_Y + BAR_H));

        // Range check happens before the subtraction so col never wraps.
        if ((g % 2) == 0) begin : g_even
            assign w_valid  = (w_x >= 11'(BAR_LX));
            assign w_col[g] = w_valid ? (w_x - 11'(BAR_LX)) : 11'd0;
        end else begin : g_odd
            assign w_valid  = (w_x < 11'(BAR_RX));
            assign w_col[g] = w_valid ? (11'(BAR_RX - 1) - w_x) : 11'd0;
        end

        assign w_front_px = 11'(w_front[g]) * 11'(PX_PER_HP);
        assign w_trail_px = 11'(w_trail[g]) * 11'(PX_PER_HP);

`ifdef LOW_HP_BLINK_EN
        assign w_blink_ok[g] = !((w_front[g] <= HPW'(HP_MAX / 4)) && (w_front[g] != '0))
                               || r_blink_cnt[3];
`else
        assign w_blink_ok[g] = 1'b1;
`endif

        assign w_bar_hit[g]   = exist_hp & w_in_row & w_valid
                                & (w_col[g] < w_front_px) & w_blink_ok[g];
        assign w_trail_hit[g] = exist_hp & w_in_row & w_valid
                                & (w_col[g] >= w_front_px) & (w_col[g] < w_trail_px);
    end

    // Lowest-index bar that lights this pixel supplies the column offset.
    always_comb begin
        w_col_sel = '0;
        for (int i = NUM_BARS - 1; i >= 0; i--) begin
            if (w_bar_hit[i] || w_trail_hit[i]) w_col_sel = w_col[i][9:0];
        end
    end

    // One-cycle output register to line up with the sprite-RAM read.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_is_bar   <= '0;
            r_is_trail <= '0;
            r_bar_col  <= '0;
        end else begin
            r_is_bar   <= w_bar_hit;
            r_is_trail <= w_trail_hit;
            r_bar_col  <= w_col_sel;
        end
    end

    assign is_bar    = r_is_bar;
    assign is_trail  = r_is_trail;
    assign bar_col   = r_bar_col;
    assign anim_busy = |w_busy;

endmodule

// File: tb/tb_hp_bar_anim.sv
// Scoreboard bench for hp_bar_anim with four bars (two rows).
module tb_hp_bar_anim;

    localparam int NB  = 4;
    localparam int HPW = 5;
    localparam int HPM = 20;

    localparam int M_IDLE  = 0;
    localparam int M_HOLD  = 1;
    localparam int M_DRAIN = 2;
    localparam int M_HEAL  = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              fc = 1'b0;
    logic              ex = 1'b1;
    logic [9:0]        dx = '0;
    logic [9:0]        dy = '0;
    logic [NB*HPW-1:0] hp = '0;
    logic [NB-1:0]     o_bar, o_trail;
    logic [9:0]        o_col;
    logic              o_busy;

    always #5 clk = ~clk;

    hp_bar_anim #(.NUM_BARS(NB)) dut (
        .Clk       (clk),
        .Reset     (rst),
        .frame_clk (fc),
        .exist_hp  (ex),
        .DrawX     (dx),
        .DrawY     (dy),
        .hp_in     (hp),
        .is_bar    (o_bar),
        .is_trail  (o_trail),
        .bar_col   (o_col),
        .anim_busy (o_busy)
    );

    typedef struct {
        logic [NB-1:0] bar;
        logic [NB-1:0] trail;
        logic [9:0]    col;
        logic          busy;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: HP values as plain integers.
    int m_front[NB], m_trail[NB], m_hold[NB], m_heal[NB], m_mode[NB];
    int m_fq, m_blink;

    function automatic void model_reset();
        for (int i = 0; i < NB; i++) begin
            m_front[i] = HPM; m_trail[i] = HPM;
            m_hold[i] = 0; m_heal[i] = 0; m_mode[i] = M_IDLE;
        end
        m_fq = 0; m_blink = 0;
    endfunction

    function automatic logic [NB*HPW-1:0] pk(input int a, input int b, input int c, input int d);
        logic [NB*HPW-1:0] r;
        r = {5'(d), 5'(c), 5'(b), 5'(a)};
        return r;
    endfunction

    function automatic exp_t pixel_expect(input int x, input int y, input logic en);
        exp_t e;
        bit found;
        e.bar = '0; e.trail = '0; e.col = '0; e.busy = 1'b0;
        found = 0;
        for (int i = 0; i < NB; i++) begin
            int ry, col, fp, tp;
            bit inrow, valid, blink_ok;
            ry    = 38 + (i / 2) * 30;
            inrow = (y >= ry) && (y < ry + 20);
            if (i % 2 == 0) begin valid = (x >= 86);  col = x - 86;  end
            else            begin valid = (x < 555);  col = 554 - x; end
            fp = m_front[i] * 10;
            tp = m_trail[i] * 10;
            blink_ok = 1;
`ifdef LOW_HP_BLINK_EN
            if (m_front[i] != 0 && m_front[i] <= HPM / 4) blink_ok = ((m_blink / 8) % 2) == 1;
`endif
            e.bar[i]   = en && inrow && valid && (col < fp) && blink_ok;
            e.trail[i] = en && inrow && valid && (col >= fp) && (col < tp);
            if (!found && (e.bar[i] || e.trail[i])) begin
                found = 1;
                e.col = 10'(col);
            end
        end
        return e;
    endfunction

    function automatic void model_frame(input logic [NB*HPW-1:0] h);
        for (int i = 0; i < NB; i++) begin
            int t;
            t = int'(h[i*HPW +: HPW]);
            if (t > HPM) t = HPM;
            if (t < m_front[i]) begin
                if (m_trail[i] < m_front[i]) m_trail[i] = m_front[i];
                m_front[i] = t;
                m_hold[i]  = 29;
                m_mode[i]  = M_HOLD;
            end else if (m_mode[i] == M_HOLD) begin
                if (m_hold[i] == 0) m_mode[i] = M_DRAIN;
                else m_hold[i]--;
            end else if (m_mode[i] == M_DRAIN) begin
                m_trail[i]--;
                if (m_trail[i] <= m_front[i]) begin m_trail[i] = m_front[i]; m_mode[i] = M_IDLE; end
            end else if (m_mode[i] == M_HEAL) begin
                if (t == m_front[i]) m_mode[i] = M_IDLE;
                else begin
                    m_heal[i] = (m_heal[i] + 1) % 4;
                    if (m_heal[i] == 0) begin
                        m_front[i]++; m_trail[i]++;
                        if (m_front[i] == t) m_mode[i] = M_IDLE;
                    end
                end
            end else begin
                if (t > m_front[i]) begin m_mode[i] = M_HEAL; m_heal[i] = 0; end
                else m_trail[i] = m_front[i];
            end
        end
        m_blink = (m_blink + 1) % 16;
    endfunction

    // Drive one cycle and push what the DUT must show one cycle later.
    task automatic step(input logic f, input int x, input int y,
                        input logic [NB*HPW-1:0] h, input logic en, input logic r);
        exp_t e;
        @(negedge clk);
        fc = f; dx = 10'(x); dy = 10'(y); hp = h; ex = en; rst = r;
        if (r) begin
            model_reset();
            e.bar = '0; e.trail = '0; e.col = '0; e.busy = 1'b0;
        end else begin
            e = pixel_expect(x, y, en);
            if (f && m_fq == 0) model_frame(h);
            m_fq = f ? 1 : 0;
            e.busy = 1'b0;
            for (int i = 0; i < NB; i++) if (m_mode[i] != M_IDLE) e.busy = 1'b1;
        end
        q.push_back(e);
    endtask

    task automatic frames(input int n, input logic [NB*HPW-1:0] h, input logic en);
        for (int k = 0; k < n; k++) begin
            for (int c = 0; c < 8; c++)
                step(c < 4, $urandom_range(0, 639), $urandom_range(30, 110), h, en, 1'b0);
        end
    endtask

    task automatic chk(input string nm, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_errors++;
            $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, got, want);
        end
    endtask

    // Monitor: one registered output sample per pushed expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("is_bar",    int'(o_bar),   int'(e.bar));
                chk("is_trail",  int'(o_trail), int'(e.trail));
                chk("bar_col",   int'(o_col),   int'(e.col));
                chk("anim_busy", int'(o_busy),  int'(e.busy));
            end
        end
    end

    initial begin
        logic [NB*HPW-1:0] h;
        int guard;
        model_reset();

        repeat (3) step(1'b0, 0, 0, pk(20, 20, 20, 20), 1'b1, 1'b1);
        h = pk(20, 20, 20, 20);
        frames(2, h, 1'b1);
        step(1'b0, 86, 38, h, 1'b1, 1'b0);
        step(1'b0, 285, 38, h, 1'b1, 1'b0);
        step(1'b0, 286, 38, h, 1'b1, 1'b0);
        step(1'b0, 86, 57, h, 1'b1, 1'b0);
        step(1'b0, 86, 58, h, 1'b1, 1'b0);
        step(1'b0, 554, 70, h, 1'b1, 1'b0);

        // Damage bar0 20->15; trail visible during hold, then drains.
        h = pk(15, 20, 20, 20);
        frames(3, h, 1'b1);
        step(1'b0, 236, 40, h, 1'b1, 1'b0);
        frames(40, h, 1'b1);

        // Bar1 down to 10, let it settle, then heal to 12.
        h = pk(15, 10, 20, 20);
        frames(40, h, 1'b1);
        h = pk(15, 12, 20, 20);
        frames(12, h, 1'b1);
        step(1'b0, 435, 38, h, 1'b1, 1'b0);

        // Second damage mid-drain.
        repeat (2) step(1'b0, 0, 0, h, 1'b1, 1'b1);
        h = pk(15, 20, 20, 20);
        frames(34, h, 1'b1);
        h = pk(10, 20, 20, 20);
        frames(3, h, 1'b1);
        step(1'b0, 250, 45, h, 1'b1, 1'b0);

        // Over-range target, damage to 0, reset mid-drain.
        h = pk(31, 0, 31, 3);
        frames(36, h, 1'b1);
        repeat (2) step(1'b0, 300, 40, h, 1'b1, 1'b1);
        step(1'b0, 100, 40, h, 1'b1, 1'b0);

        // Overlay disabled while animation runs, then re-enabled.
        h = pk(5, 5, 4, 20);
        frames(20, h, 1'b0);
        frames(20, h, 1'b1);

        // Randomised phase.
        for (int fr = 0; fr < 1200; fr++) begin
            int hi, lo;
            logic en;
            if ($urandom_range(0, 15) == 0)
                for (int i = 0; i < NB; i++) h[i*HPW +: HPW] = 5'($urandom_range(0, 31));
            en = ($urandom_range(0, 9) != 0);
            hi = $urandom_range(1, 4);
            lo = $urandom_range(1, 4);
            for (int c = 0; c < hi + lo; c++)
                step(c < hi, $urandom_range(0, 639), $urandom_range(30, 110), h, en,
                     $urandom_range(0, 1999) == 0);
        end

        guard = 0;
        while (q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        #2;
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL drain_queue left=%0d want=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
